// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the CPU single-step / run / burst controller.
package cpu_step_ctrl_pkg;

   localparam int unsigned BurstW = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStep  = 2'd1,
      StRun   = 2'd2,
      StBurst = 2'd3
   } state_e;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchroniser, tick-sampled debouncer and a
// one-cycle pulse on the debounced rising edge.
module btn_debounce #(
   parameter int unsigned DEB_TICKS = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn,
   output logic press
);

   localparam int unsigned CntW = $clog2(DEB_TICKS + 1);

   logic            sync1;
   logic            sync2;
   logic            level;
   logic [CntW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (tick) begin
            // Any sample agreeing with the accepted level restarts the count.
            if (sync2 == level) begin
               cnt <= '0;
            end else if (cnt == CntW'(DEB_TICKS - 1)) begin
               cnt   <= '0;
               level <= sync2;
               press <= sync2;
            end else begin
               cnt <= cnt + CntW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Debug clock-enable controller: single step, free run and N-step burst,
// driven by three debounced push buttons.
module cpu_step_ctrl
   import cpu_step_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 100000,
   parameter int unsigned DEB_TICKS = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_step,
   input  logic              btn_run,
   input  logic              btn_burst,
   input  logic [BurstW-1:0] burst_n,
   input  logic              cpu_halted,
   output logic              cpu_ce,
   output logic [1:0]        state,
   output logic              step_done,
   output logic              tick_1k
);

   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [TickW-1:0]  tick_cnt;
   state_e            state_q;
   logic [BurstW-1:0] remain;
   logic              step_press;
   logic              run_press;
   logic              burst_press;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
         tick_1k  <= 1'b0;
      end else if (tick_cnt == TickW'(TICK_DIV - 1)) begin
         tick_cnt <= '0;
         tick_1k  <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt + TickW'(1);
         tick_1k  <= 1'b0;
      end
   end

   btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_step (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_1k),
      .btn   (btn_step),
      .press (step_press)
   );

   btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_run (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_1k),
      .btn   (btn_run),
      .press (run_press)
   );

   btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_burst (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_1k),
      .btn   (btn_burst),
      .press (burst_press)
   );

   // cpu_ce is registered alongside the state so it is high exactly in
   // STEP, RUN and BURST cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cpu_ce    <= 1'b0;
         step_done <= 1'b0;
         remain    <= '0;
      end else begin
         step_done <= 1'b0;
         case (state_q)
            StIdle: begin
               cpu_ce <= 1'b0;
               if (!cpu_halted) begin
                  if (run_press) begin
                     state_q <= StRun;
                     cpu_ce  <= 1'b1;
                  end else if (burst_press) begin
                     if (burst_n != '0) begin
                        state_q <= StBurst;
                        remain  <= burst_n;
                        cpu_ce  <= 1'b1;
                     end
                  end else if (step_press) begin
                     state_q <= StStep;
                     cpu_ce  <= 1'b1;
                  end
               end
            end
            StStep: begin
               state_q   <= StIdle;
               cpu_ce    <= 1'b0;
               step_done <= 1'b1;
            end
            StRun: begin
               if (run_press || cpu_halted) begin
                  state_q <= StIdle;
                  cpu_ce  <= 1'b0;
               end else begin
                  cpu_ce <= 1'b1;
               end
            end
            StBurst: begin
               if (cpu_halted) begin
                  state_q <= StIdle;
                  cpu_ce  <= 1'b0;
                  remain  <= '0;
               end else begin
                  remain <= remain - BurstW'(1);
                  if (remain == BurstW'(1)) begin
                     state_q   <= StIdle;
                     cpu_ce    <= 1'b0;
                     step_done <= 1'b1;
                  end else begin
                     cpu_ce <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               cpu_ce  <= 1'b0;
            end
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench: stimulus queues the expected cpu_ce episodes, a monitor
// measures each episode the DUT produces and checks it against the queue.
module tb_cpu_step_ctrl;

   localparam int unsigned TickDiv  = 4;
   localparam int unsigned DebTicks = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_step;
   logic        btn_run;
   logic        btn_burst;
   logic [15:0] burst_n;
   logic        cpu_halted;
   logic        cpu_ce;
   logic [1:0]  state;
   logic        step_done;
   logic        tick_1k;

   typedef struct {
      int kind;
      int len;
      bit done;
   } ep_t;

   ep_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   bit in_ep = 0;
   int ep_state;
   int ep_len;
   bit ep_bad;
   int cyc = 0;
   int last_tick = 0;
   bit tick_ok = 0;

   cpu_step_ctrl #(
      .TICK_DIV  (TickDiv),
      .DEB_TICKS (DebTicks)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_step   (btn_step),
      .btn_run    (btn_run),
      .btn_burst  (btn_burst),
      .burst_n    (burst_n),
      .cpu_halted (cpu_halted),
      .cpu_ce     (cpu_ce),
      .state      (state),
      .step_done  (step_done),
      .tick_1k    (tick_1k)
   );

   always #5 clk = ~clk;

   // kind: 1 step, 2 run, 3 burst; len 0 means any length
   task automatic push_exp(input int kind, input int len, input bit done);
      ep_t e;
      e.kind = kind;
      e.len  = len;
      e.done = done;
      exp_q.push_back(e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ce(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (cpu_ce) begin
            ok = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_ce: cpu_ce=0 for 200 cycles, required 1");
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!cpu_ce) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_idle: cpu_ce=1 for 400 cycles, required 0");
      end
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         0: btn_step = v;
         1: btn_run = v;
         default: btn_burst = v;
      endcase
   endtask

   task automatic press(input int which);
      set_btn(which, 1'b1);
      wait_cycles(16);
      set_btn(which, 1'b0);
      wait_cycles(16);
      wait_idle();
      wait_cycles(4);
   endtask

   task automatic glitch(input int which, input int len);
      set_btn(which, 1'b1);
      wait_cycles(len);
      set_btn(which, 1'b0);
      wait_cycles(16);
   endtask

   task automatic burst_op(input int n);
      bit ok;
      burst_n = 16'(n);
      if (n == 0) begin
         press(2);
      end else begin
         push_exp(3, n, 1'b1);
         btn_burst = 1'b1;
         wait_ce(ok);
         burst_n = 16'($urandom);
         wait_cycles(16);
         btn_burst = 1'b0;
         wait_cycles(16);
         wait_idle();
         wait_cycles(4);
      end
   endtask

   // Run started by btn_run (optionally with btn_step together), stopped by
   // cpu_halted so that cpu_ce is high for exactly k cycles.
   task automatic run_halt(input int k, input bit with_step);
      bit ok;
      push_exp(2, k, 1'b0);
      btn_run = 1'b1;
      if (with_step) btn_step = 1'b1;
      wait_ce(ok);
      wait_cycles(k - 1);
      cpu_halted = 1'b1;
      wait_cycles(1);
      wait_idle();
      wait_cycles(16);
      btn_run  = 1'b0;
      btn_step = 1'b0;
      wait_cycles(16);
   endtask

   // Monitor / scoreboard
   initial begin
      ep_t e;
      forever begin
         @(negedge clk);
         if (in_ep && (!cpu_ce || rst)) begin
            in_ep = 0;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL episode: got state=%0d len=%0d step_done=%0b, required no episode",
                        ep_state, ep_len, step_done);
            end else begin
               e = exp_q.pop_front();
               if (ep_state != e.kind || (e.len != 0 && ep_len != e.len) ||
                   step_done != e.done || state != 2'd0 || ep_bad) begin
                  n_fail++;
                  $display("FAIL episode: got state=%0d len=%0d done=%0b end_state=%0d bad=%0b, required state=%0d len=%0d done=%0b end_state=0",
                           ep_state, ep_len, step_done, state, ep_bad, e.kind, e.len, e.done);
               end
            end
         end else if (step_done && !rst) begin
            n_tests++;
            n_fail++;
            $display("FAIL step_done: got stray pulse at cycle %0d, required 0", cyc);
         end
         if (rst) begin
            tick_ok = 0;
         end else begin
            cyc++;
            if (tick_1k) begin
               if (tick_ok) begin
                  n_tests++;
                  if (cyc - last_tick != int'(TickDiv)) begin
                     n_fail++;
                     $display("FAIL tick_period: got %0d, required %0d", cyc - last_tick, TickDiv);
                  end
               end
               last_tick = cyc;
               tick_ok   = 1;
            end
            if (cpu_ce) begin
               if (!in_ep) begin
                  in_ep    = 1;
                  ep_state = int'(state);
                  ep_len   = 0;
                  ep_bad   = 0;
               end
               ep_len++;
               if (int'(state) != ep_state) ep_bad = 1;
            end
         end
      end
   end

   initial begin
      bit ok;
      rst        = 1'b1;
      btn_step   = 1'b0;
      btn_run    = 1'b0;
      btn_burst  = 1'b0;
      burst_n    = 16'd0;
      cpu_halted = 1'b0;
      #20;
      n_tests++;
      if (cpu_ce !== 1'b0 || state !== 2'd0 || step_done !== 1'b0 || tick_1k !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: got ce=%b state=%0d done=%b tick=%b, required all 0",
                  cpu_ce, state, step_done, tick_1k);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_cycles(8);

      // Single step, then a one-tick glitch that must be rejected
      push_exp(1, 1, 1'b1);
      press(0);
      glitch(0, int'(TickDiv));

      burst_op(5);
      burst_op(0);

      run_halt(10, 1'b0);
      // Step and run debounce together: run wins
      cpu_halted = 1'b0;
      wait_cycles(4);
      run_halt(7, 1'b1);
      // Still halted: step press ignored
      press(0);
      cpu_halted = 1'b0;
      wait_cycles(4);

      // RUN ignores step/burst, stops on a second run press
      push_exp(2, 0, 1'b0);
      btn_run = 1'b1;
      wait_ce(ok);
      wait_cycles(16);
      btn_run = 1'b0;
      wait_cycles(16);
      burst_n = 16'd5;
      glitch(0, 16);
      glitch(2, 16);
      press(1);

      // Reset in the middle of a long burst, button held through reset
      burst_n = 16'd100;
      push_exp(3, 0, 1'b0);
      push_exp(3, 3, 1'b1);
      btn_burst = 1'b1;
      wait_ce(ok);
      burst_n = 16'd3;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (cpu_ce !== 1'b0 || state !== 2'd0 || step_done !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got ce=%b state=%0d done=%b, required 0 0 0",
                  cpu_ce, state, step_done);
      end
      wait_cycles(3);
      rst = 1'b0;
      wait_cycles(20);
      btn_burst = 1'b0;
      wait_cycles(16);
      wait_idle();
      wait_cycles(4);

      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 3))
            0: begin
               push_exp(1, 1, 1'b1);
               press(0);
            end
            1: burst_op(int'($urandom_range(0, 20)));
            2: begin
               run_halt(int'($urandom_range(1, 30)), 1'b0);
               cpu_halted = 1'b0;
               wait_cycles(4);
            end
            default: glitch(int'($urandom_range(0, 2)), int'($urandom_range(1, TickDiv)));
         endcase
      end

      wait_cycles(20);
      n_tests++;
      if (exp_q.size() != 0 || in_ep) begin
         n_fail++;
         $display("FAIL drain: got %0d pending episodes (in_ep=%0b), required 0",
                  exp_q.size(), in_ep);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000, means clk cycles per 1 kHz sample tick.
REQ-002 Parameter DEB_TICKS, default 20, means consecutive equal tick samples required to accept a button level.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_step  input  1  raw single-step button, asynchronous, active-high.
REQ-006 btn_run  input  1  raw run/stop toggle button, asynchronous, active-high.
REQ-007 btn_burst  input  1  raw N-step button, asynchronous, active-high.
REQ-008 burst_n  input  16  N-step count, sampled on burst start.
REQ-009 cpu_halted  input  1  CPU halt status, synchronous to clk.
REQ-010 cpu_ce  output  1  CPU clock enable; one CPU cycle per high clk cycle.
REQ-011 state  output  2  FSM state: 0 IDLE, 1 STEP, 2 RUN, 3 BURST.
REQ-012 step_done  output  1  one-cycle pulse on completion of STEP or BURST.
REQ-013 tick_1k  output  1  one-cycle sample-tick pulse.

Function
REQ-014 tick_1k SHALL pulse for one cycle whenever its counter equals TICK_DIV-1; the counter then wraps to 0.
REQ-015 Each button SHALL pass through a 2-flop synchroniser, then a debouncer sampling only on tick_1k.
REQ-016 The debounced level SHALL change only after DEB_TICKS consecutive tick samples differ from the current level; any agreeing sample clears the count.
REQ-017 A press event SHALL be a one-cycle pulse on the debounced rising edge; releases generate no event.
REQ-018 IDLE: with cpu_halted=1, all press events SHALL be ignored.
REQ-019 IDLE: otherwise, priority SHALL be run > burst > step.
REQ-020 IDLE: a run press -> RUN.
REQ-021 IDLE: a burst press with burst_n!=0 -> BURST, loading a 16-bit remaining counter with burst_n.
REQ-022 IDLE: a burst press with burst_n=0 -> remain IDLE with no cpu_ce and no step_done.
REQ-023 IDLE: a step press -> STEP.
REQ-024 State transitions SHALL occur on the clk edge after the cycle in which the press pulse is high.
REQ-025 STEP SHALL last exactly one cycle with cpu_ce=1, then return to IDLE with step_done=1 in that first IDLE cycle.
REQ-026 RUN SHALL hold cpu_ce=1 every cycle.
REQ-027 RUN SHALL exit to IDLE on a run press or on cpu_halted=1; cpu_ce SHALL be 0 in the cycle cpu_halted is seen high.
REQ-028 RUN SHALL ignore step and burst presses.
REQ-029 BURST SHALL assert cpu_ce for exactly burst_n consecutive cycles, decrementing the remaining counter each cycle.
REQ-030 BURST SHALL return to IDLE with a step_done pulse when the counter reaches 0.
REQ-031 BURST SHALL abort to IDLE without step_done on cpu_halted=1, with cpu_ce=0 in that cycle.
REQ-032 BURST SHALL ignore all presses; changes to burst_n mid-burst have no effect.
REQ-033 cpu_ce, state and step_done SHALL be registered outputs; cpu_ce=1 only in STEP, RUN and BURST.

Reset
REQ-034 rst SHALL asynchronously force: state=IDLE, cpu_ce=0, step_done=0, tick_1k=0, tick counter=0, burst counter=0, synchronisers=0, debounced levels=0, debounce counts=0.
REQ-035 Reset mid-RUN or mid-BURST SHALL stop cpu_ce immediately; a button held through reset SHALL produce a press event once debounced after release of rst.

Structure
REQ-036 State encodings (IDLE/STEP/RUN/BURST) and the burst counter width SHALL be defined in a shared package.
REQ-037 One sub-module, btn_debounce (synchroniser, debouncer and rising-edge pulse, parameter DEB_TICKS, tick input), SHALL be instantiated three times; the tick counter SHALL stay in cpu_step_ctrl.

Verification (TICK_DIV=4, DEB_TICKS=2)
REQ-038 Hold btn_step high for 3 ticks -> exactly one cpu_ce cycle, state 0->1->0, one step_done pulse.
REQ-039 btn_step glitching high for 1 tick only -> no event, cpu_ce stays 0.
REQ-040 burst_n=5, press btn_burst -> 5 consecutive cpu_ce cycles then step_done; repeat with burst_n=0 -> no cpu_ce.
REQ-041 Press btn_run, then raise cpu_halted after 10 cycles -> cpu_ce high 10 cycles, state returns to 0; a later step press is ignored while cpu_halted=1.
REQ-042 btn_run and btn_step debounce on the same cycle -> RUN entered, no STEP.
REQ-043 Assert rst during BURST with burst_n=100 -> cpu_ce=0 and state=0 asynchronously, with no step_done.
